// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: RAW hazard tracking for Decode; per-source forwarding selects,
// load-use stall with configurable load latency, and a saturating stall counter.
module hazard_forward_unit #(
  parameter int DEPTH = 3,
  parameter int LOAD_LAT = 1,
  parameter int STALL_CNT_W = 16,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [31:0]            Instruction,
  input  logic                   InstrValid,
  input  logic                   Flush,
  output logic                   Stall,
  output logic [FW-1:0]          FwdA,
  output logic [FW-1:0]          FwdB,
  output logic [STALL_CNT_W-1:0] StallCnt
);
  logic [5:0] op;
  logic [4:0] rs, rt, dest;
  logic is_r, is_lw, is_sw, is_beq, is_imm, rs_rd, rt_rd, wr, active, push;
  logic [DEPTH-1:0] v, ld;
  logic [4:0] d [DEPTH];
  logic [FW-1:0] fa, fb;
  logic la, lb;
  logic unused_ok;
  assign op = Instruction[31:26];
  assign rs = Instruction[25:21];
  assign rt = Instruction[20:16];
  assign is_r = op == 6'b000000;
  assign is_lw = op == 6'b100011;
  assign is_sw = op == 6'b101011;
  assign is_beq = op == 6'b000100;
  assign is_imm = op == 6'b001000 || op == 6'b001101;
  assign dest = is_r ? Instruction[15:11] : rt;
  assign wr = (is_r || is_lw || is_imm) && dest != 5'd0;
  assign rs_rd = is_r || is_lw || is_sw || is_beq || is_imm;
  assign rt_rd = is_r || is_sw || is_beq;
  assign unused_ok = ^Instruction[10:0];
  // Scan farthest to nearest so the nearest matching stage is left standing.
  always_comb begin
    fa = '0;
    fb = '0;
    la = 1'b0;
    lb = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v[k] && rs_rd && d[k] == rs) begin
        fa = FW'(k + 1);
        la = ld[k] && k < LOAD_LAT;
      end
      if (v[k] && rt_rd && d[k] == rt) begin
        fb = FW'(k + 1);
        lb = ld[k] && k < LOAD_LAT;
      end
    end
  end
  assign active = InstrValid && !Flush;
  assign Stall = active && (la || lb);
  assign FwdA = (active && !la) ? fa : '0;
  assign FwdB = (active && !lb) ? fb : '0;
  assign push = active && !Stall && wr;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      v <= '0;
      ld <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= 5'd0;
      StallCnt <= '0;
    end else begin
      v[0] <= push;
      ld[0] <= is_lw;
      d[0] <= dest;
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= v[k-1];
        ld[k] <= ld[k-1];
        d[k] <= d[k-1];
      end
      if (Stall && !(&StallCnt)) StallCnt <= StallCnt + STALL_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: table-driven checks of two configurations (3/1 and 4/2) with a scoreboard queue.
module tb_hazard_forward_unit;
  logic Clk = 1'b0, Rst = 1'b0;
  logic [31:0] Instruction = '0;
  logic InstrValid = 1'b0, Flush = 1'b0;
  logic st3, st4;
  logic [1:0] fa3, fb3;
  logic [2:0] fa4, fb4;
  logic [15:0] cnt3, cnt4;
  int n_cmp = 0, n_bad = 0;

  always #5 Clk = ~Clk;

  hazard_forward_unit u3 (.Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InstrValid(InstrValid),
    .Flush(Flush), .Stall(st3), .FwdA(fa3), .FwdB(fb3), .StallCnt(cnt3));
  hazard_forward_unit #(.DEPTH(4), .LOAD_LAT(2)) u4 (.Clk(Clk), .Rst(Rst), .Instruction(Instruction),
    .InstrValid(InstrValid), .Flush(Flush), .Stall(st4), .FwdA(fa4), .FwdB(fb4), .StallCnt(cnt4));

  localparam logic [31:0] ADD = 32'h00221820, SUB = 32'h00652022, LW = 32'h8C230000, ADD2 = 32'h00622020;
  localparam logic [31:0] NOP = 32'h0, ADD3 = 32'h00432020, ADD0 = 32'h00220020, ADDZ = 32'h00002020;
  localparam logic [31:0] SW = 32'hAC230000, ADD4 = 32'h00802820;

  typedef struct {logic rst, sel; logic [31:0] ins; logic iv, fl, st; logic [2:0] fa, fb; logic [15:0] cnt;} vec_t;
  typedef struct {logic sel, st; logic [2:0] fa, fb; logic [15:0] cnt;} exp_t;
  vec_t tbl[$];
  exp_t q[$];

  function automatic vec_t mk(logic rst, logic sel, logic [31:0] ins, logic iv, logic fl, logic st,
                              logic [2:0] fa, logic [2:0] fb, logic [15:0] cnt);
    vec_t r;
    r.rst = rst; r.sel = sel; r.ins = ins; r.iv = iv; r.fl = fl;
    r.st = st; r.fa = fa; r.fb = fb; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic sample(string tag);
    exp_t e;
    e = q.pop_front();
    chk({tag, " stall"}, 16'(e.sel ? st4 : st3), 16'(e.st));
    chk({tag, " fwda"}, 16'(e.sel ? fa4 : {1'b0, fa3}), 16'(e.fa));
    chk({tag, " fwdb"}, 16'(e.sel ? fb4 : {1'b0, fb3}), 16'(e.fb));
    chk({tag, " cnt"}, e.sel ? cnt4 : cnt3, e.cnt);
  endtask

  task automatic apply(vec_t v, string tag);
    exp_t e;
    @(negedge Clk);
    if (v.rst) begin
      Rst = 1'b1;
      #1 Rst = 1'b0;
    end
    Instruction = v.ins; InstrValid = v.iv; Flush = v.fl;
    e.sel = v.sel; e.st = v.st; e.fa = v.fa; e.fb = v.fb; e.cnt = v.cnt;
    q.push_back(e);
    #2 sample(tag);
  endtask

  initial begin
    // forwarding from E
    tbl.push_back(mk(1, 0, ADD,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, SUB,  1, 0, 0, 1, 0, 0));
    // load-use, one stall cycle
    tbl.push_back(mk(1, 0, LW,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, ADD2, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, ADD2, 1, 0, 0, 2, 0, 1));
    tbl.push_back(mk(0, 0, NOP,  1, 0, 0, 0, 0, 1));
    // forwarding from W, then nearest wins
    tbl.push_back(mk(1, 0, ADD,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, ADD3, 1, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 0, ADD,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, ADD,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, ADD3, 1, 0, 0, 0, 1, 0));
    // $0 never forwards; sw is not a writer
    tbl.push_back(mk(1, 0, ADD0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, ADDZ, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, ADD,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, SW,   1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, ADD3, 1, 0, 0, 0, 2, 0));
    // flush and invalid gating
    tbl.push_back(mk(1, 0, LW,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, ADD2, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, ADD4, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, LW,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, ADD2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, ADD2, 1, 0, 0, 2, 0, 0));
    // DEPTH=4, LOAD_LAT=2: two stall cycles then forward from stage 3
    tbl.push_back(mk(1, 1, LW,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, ADD2, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, ADD2, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, ADD2, 1, 0, 0, 3, 0, 2));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    // asynchronous reset in the middle of a stall
    apply(mk(1, 1, LW, 1, 0, 0, 0, 0, 0), "rst_lw");
    apply(mk(0, 1, ADD2, 1, 0, 1, 0, 0, 0), "rst_stall");
    Rst = 1'b1;
    #1;
    chk("rst_async stall", 16'(st4), 16'd0);
    chk("rst_async cnt", cnt4, 16'd0);
    chk("rst_async fwda", 16'(fa4), 16'd0);
    Rst = 1'b0;
    apply(mk(0, 1, ADD2, 1, 0, 0, 0, 0, 0), "rst_after");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
